// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - two-requester round-robin arbiter in front of a single I2C write engine
//
// Ports:
//   clk_100          system clock, single domain
//   rst_100          synchronous active-high reset
//   m0_req, m1_req   one-cycle write request; m0 = config sequencer, m1 = runtime control
//   m0_data, m1_data {dev_addr[7:0], reg[15:0], val[7:0]}, sampled with mN_req
//   m0_ack, m1_ack   one-cycle completion pulse
//   m0_tout, m1_tout one-cycle pulse with mN_ack when the transfer timed out
//   m0_busy, m1_busy request held, from capture until mN_ack
//   m0_ovf, m1_ovf   sticky: a request arrived while one was already held and was dropped
//   eng_req          one-cycle request to the I2C engine
//   eng_data         word for the engine, held from ISSUE until the next ISSUE
//   eng_ack          one-cycle done pulse from the engine
module i2c_arbiter #(
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic        clk_100,
  input  logic        rst_100,
  input  logic        m0_req,
  input  logic [31:0] m0_data,
  input  logic        m1_req,
  input  logic [31:0] m1_data,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic        m0_tout,
  output logic        m1_tout,
  output logic        m0_busy,
  output logic        m1_busy,
  output logic        m0_ovf,
  output logic        m1_ovf,
  output logic        eng_req,
  output logic [31:0] eng_data,
  input  logic        eng_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam bit          TIMEOUT_EN = (TIMEOUT_CYC != 0);
  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYC - 1);

  state_t      state, state_nxt;
  logic        pend0, pend1;
  logic [31:0] data0, data1;
  logic        ovf0, ovf1;
  logic        grant, grant_nxt;
  logic        last_grant;
  logic        timed_out, timed_out_nxt;
  logic [31:0] timer;
  logic        tout_hit;
  logic        done0, done1;
  logic        accept0, accept1;

  always_ff @(posedge clk_100) begin
    if (rst_100) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    timed_out_nxt = timed_out;
    tout_hit      = TIMEOUT_EN && (timer == TIMER_LAST);
    eng_req       = 1'b0;
    m0_ack        = 1'b0;
    m1_ack        = 1'b0;
    m0_tout       = 1'b0;
    m1_tout       = 1'b0;

    case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          state_nxt = ISSUE;
          // On a tie the requester that was not served last wins.
          if (pend0 && pend1) grant_nxt = ~last_grant;
          else                grant_nxt = pend1;
        end
      end
      ISSUE: begin
        eng_req       = 1'b1;
        timed_out_nxt = 1'b0;
        state_nxt     = WAIT;
      end
      WAIT: begin
        // A completion in the same cycle as the timeout terminal counts as ok.
        if (eng_ack) begin
          timed_out_nxt = 1'b0;
          state_nxt     = DONE;
        end else if (tout_hit) begin
          timed_out_nxt = 1'b1;
          state_nxt     = DONE;
        end
      end
      DONE: begin
        m0_ack    = ~grant;
        m1_ack    = grant;
        m0_tout   = ~grant & timed_out;
        m1_tout   = grant & timed_out;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A request arriving in the DONE cycle of its own transfer refills the
  // slot being released rather than being counted as an overflow.
  assign done0   = (state == DONE) && !grant;
  assign done1   = (state == DONE) && grant;
  assign accept0 = m0_req && (!pend0 || done0);
  assign accept1 = m1_req && (!pend1 || done1);

  always_ff @(posedge clk_100) begin
    if (rst_100) begin
      pend0      <= 1'b0;
      pend1      <= 1'b0;
      data0      <= '0;
      data1      <= '0;
      ovf0       <= 1'b0;
      ovf1       <= 1'b0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      timed_out  <= 1'b0;
      timer      <= '0;
      eng_data   <= '0;
    end else begin
      grant     <= grant_nxt;
      timed_out <= timed_out_nxt;

      if (state == IDLE && state_nxt == ISSUE) begin
        eng_data <= grant_nxt ? data1 : data0;
      end

      if (state == ISSUE) begin
        timer <= '0;
      end else if (state == WAIT) begin
        timer <= timer + 32'd1;
      end

      if (state == DONE) begin
        last_grant <= grant;
      end

      if (accept0) begin
        pend0 <= 1'b1;
        data0 <= m0_data;
      end else if (done0) begin
        pend0 <= 1'b0;
      end
      if (m0_req && !accept0) ovf0 <= 1'b1;

      if (accept1) begin
        pend1 <= 1'b1;
        data1 <= m1_data;
      end else if (done1) begin
        pend1 <= 1'b0;
      end
      if (m1_req && !accept1) ovf1 <= 1'b1;
    end
  end

  assign m0_busy = pend0;
  assign m1_busy = pend1;
  assign m0_ovf  = ovf0;
  assign m1_ovf  = ovf1;

endmodule
